// File: rtl/skinny_sbox8_domd_sched.sv
// skinny_sbox8_domd_sched
// Sequencer that time-shares one masked SKINNY sbox8 across a full shared state.
// Each shared byte is held at the sbox for LAT consecutive fresh-randomness
// cycles. The registered sbox output is written back in place into the work
// buffer. Shares are only routed here and are never combined.
module skinny_sbox8_domd_sched #(
  parameter int d      = 2,
  parameter int NBYTES = 16,
  parameter int LAT    = 4,
  parameter int SB     = 8 * (d + 1),
  parameter int R      = 8 * d * (d + 1) / 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NBYTES*SB-1:0] in_state,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NBYTES*SB-1:0] out_state,
  input  logic [R-1:0]         rnd_in,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  output logic [SB-1:0]        sb_si,
  output logic [R-1:0]         sb_r,
  input  logic [SB-1:0]        sb_so
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]    state_r;
  logic [IW-1:0] idx_r;
  logic [IW-1:0] pidx_r;
  logic [CW-1:0] cnt_r;
  logic          pend_r;
  logic [SB-1:0] buf_r [NBYTES];

  logic fresh_s;
  logic last_cyc_s;
  logic last_byte_s;

  assign fresh_s     = (state_r == ST_RUN) && rnd_valid;
  assign last_cyc_s  = (cnt_r == CW'(LAT - 1));
  assign last_byte_s = (idx_r == IW'(NBYTES - 1));

  assign in_ready  = (state_r == ST_IDLE);
  assign rnd_ready = (state_r == ST_RUN);
  assign out_valid = (state_r == ST_DONE);

  for (genvar k = 0; k < NBYTES; k++) begin : g_out
    assign out_state[k*SB +: SB] = buf_r[k];
  end

  // Sbox feed: current byte and fresh randomness only on fresh RUN cycles, zero otherwise.
  always_comb begin
    sb_si = {SB{1'b0}};
    sb_r  = {R{1'b0}};
    if (fresh_s) begin
      sb_si = buf_r[idx_r];
      sb_r  = rnd_in;
    end else begin
      sb_si = {SB{1'b0}};
      sb_r  = {R{1'b0}};
    end
  end

  // Control FSM: byte index, fresh-cycle counter and pending-capture bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= {IW{1'b0}};
      pidx_r  <= {IW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      pend_r  <= 1'b0;
    end else begin
      // A pending capture always completes this cycle; a newly finished byte re-arms it below.
      pend_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            idx_r   <= {IW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            pend_r  <= 1'b0;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (rnd_valid) begin
            if (last_cyc_s) begin
              cnt_r  <= {CW{1'b0}};
              pend_r <= 1'b1;
              pidx_r <= idx_r;
              idx_r  <= idx_r + IW'(1);
              if (last_byte_s) begin
                state_r <= ST_FLUSH;
              end
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end else begin
            // Missing randomness: the byte must start over with LAT fresh cycles.
            cnt_r <= {CW{1'b0}};
          end
        end
        ST_FLUSH: begin
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Work buffer: load the whole state on accept, then write back each sbox result in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NBYTES; k++) begin
        buf_r[k] <= {SB{1'b0}};
      end
    end else if ((state_r == ST_IDLE) && in_valid) begin
      for (int k = 0; k < NBYTES; k++) begin
        buf_r[k] <= in_state[k*SB +: SB];
      end
    end else if (pend_r) begin
      buf_r[pidx_r] <= sb_so;
    end
  end

endmodule

// File: tb/tb_skinny_sbox8_domd_sched.sv
// Directed testbench for skinny_sbox8_domd_sched with a behavioural masked sbox
// of LAT registered stages. The sbox model only produces the true result when
// all LAT stages saw the same input on fresh-randomness cycles.
module tb_skinny_sbox8_domd_sched;

  localparam int D   = 2;
  localparam int NB  = 16;
  localparam int LAT = 4;
  localparam int SB  = 8 * (D + 1);
  localparam int R   = 8 * D * (D + 1) / 2;
  localparam int W   = NB * SB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_state;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_state;
  logic [R-1:0]  rnd_in;
  logic          rnd_valid;
  logic          rnd_ready;
  logic [SB-1:0] sb_si;
  logic [R-1:0]  sb_r;
  logic [SB-1:0] sb_so;

  int n_chk  = 0;
  int n_fail = 0;

  skinny_sbox8_domd_sched #(.d(D), .NBYTES(NB), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .sb_si(sb_si), .sb_r(sb_r), .sb_so(sb_so)
  );

  always #5 clk = ~clk;

  // SKINNY sbox8 values for the inputs this bench uses.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    case (x)
      8'h00: return 8'h65; 8'h01: return 8'h4c; 8'h02: return 8'h6a; 8'h03: return 8'h42;
      8'h04: return 8'h4b; 8'h05: return 8'h63; 8'h06: return 8'h43; 8'h07: return 8'h6b;
      8'h08: return 8'h55; 8'h09: return 8'h75; 8'h0a: return 8'h5a; 8'h0b: return 8'h7a;
      8'h0c: return 8'h53; 8'h0d: return 8'h73; 8'h0e: return 8'h5b; 8'h0f: return 8'h7b;
      8'hff: return 8'hff;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] unmask_byte(input logic [SB-1:0] s);
    return s[7:0] ^ s[15:8] ^ s[23:16];
  endfunction

  function automatic logic [127:0] unmask_state(input logic [W-1:0] s);
    logic [127:0] r;
    r = 128'h0;
    for (int k = 0; k < NB; k++) r[8*k +: 8] = unmask_byte(s[k*SB +: SB]);
    return r;
  endfunction

  function automatic logic [W-1:0] mask_state(input logic [127:0] p);
    logic [W-1:0] s;
    logic [7:0]   m0, m1;
    s = '0;
    for (int k = 0; k < NB; k++) begin
      m0 = 8'($urandom);
      m1 = 8'($urandom);
      s[k*SB +: SB] = {p[8*k +: 8] ^ m0 ^ m1, m1, m0};
    end
    return s;
  endfunction

  // Behavioural masked sbox: LAT register stages, remasked output.
  logic [SB-1:0] pipe_q [LAT];
  logic          vld_q  [LAT];
  logic [15:0]   msk_q;
  logic          all_ok;
  logic [7:0]    so_val;

  initial begin
    for (int i = 0; i < LAT; i++) begin
      pipe_q[i] = '0;
      vld_q[i]  = 1'b0;
    end
    msk_q = 16'h0;
  end

  always @(posedge clk) begin
    pipe_q[0] <= sb_si;
    vld_q[0]  <= rnd_valid & rnd_ready;
    for (int i = 1; i < LAT; i++) begin
      pipe_q[i] <= pipe_q[i-1];
      vld_q[i]  <= vld_q[i-1];
    end
    msk_q <= 16'($urandom);
  end

  always_comb begin
    all_ok = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      if (!vld_q[i] || (pipe_q[i] !== pipe_q[LAT-1])) all_ok = 1'b0;
    end
    so_val = all_ok ? sbox_ref(unmask_byte(pipe_q[LAT-1]))
                    : ~sbox_ref(unmask_byte(pipe_q[LAT-1]));
    sb_so  = {so_val ^ msk_q[7:0] ^ msk_q[15:8], msk_q[15:8], msk_q[7:0]};
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation, starting in an IDLE cycle just after a rising edge.
  task automatic run_op(input string tag, input logic [127:0] pt, input int st1, input int st2,
                        input int hold, input int abort_at, input bit chain,
                        input logic [127:0] nxt, input int exp_ov, input int exp_fresh,
                        input logic [127:0] exp_ct);
    int       ov_cyc, fresh_n, sbr_err, stab_err, ov_len;
    bit       fin;
    logic [W-1:0] snap;
    ov_cyc = -1; fresh_n = 0; sbr_err = 0; stab_err = 0; ov_len = 0; fin = 1'b0; snap = '0;
    check({tag, "_in_ready_idle"}, W'(in_ready), W'(1'b1));
    in_valid  = 1'b1;
    in_state  = mask_state(pt);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 400 && !fin; c++) begin
      rnd_valid = (c != st1) && (c != st2);
      rnd_in    = R'($urandom);
      if (abort_at == c) rst_n = 1'b0;
      #1;
      if (rnd_ready && rnd_valid) begin
        fresh_n++;
        if (sb_r !== rnd_in) sbr_err++;
      end else if ((sb_r !== '0) || (sb_si !== '0)) begin
        sbr_err++;
      end
      if (out_valid) begin
        ov_len++;
        if (ov_cyc < 0) begin
          ov_cyc = c;
          snap   = out_state;
          if (chain) begin
            in_valid = 1'b1;
            in_state = mask_state(nxt);
          end
        end else if (out_state !== snap) begin
          stab_err++;
        end
        if (in_ready) stab_err++;
        if (c - ov_cyc >= hold) begin
          out_ready = 1'b1;
          fin       = 1'b1;
        end else begin
          out_ready = 1'b0;
        end
      end
      if (abort_at == c) fin = 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    if (abort_at > 0) begin
      rst_n = 1'b1;
      check({tag, "_rst_in_ready"}, W'(in_ready), W'(1'b1));
      check({tag, "_rst_rnd_ready"}, W'(rnd_ready), W'(1'b0));
      check({tag, "_rst_out_valid"}, W'(out_valid), W'(1'b0));
      check({tag, "_rst_out_state"}, out_state, '0);
    end else begin
      check({tag, "_ov_cycle"}, W'(ov_cyc), W'(exp_ov));
      check({tag, "_ov_len"}, W'(ov_len), W'(hold + 1));
      check({tag, "_result"}, W'(unmask_state(snap)), W'(exp_ct));
      check({tag, "_fresh_cnt"}, W'(fresh_n), W'(exp_fresh));
      check({tag, "_sbox_feed"}, W'(sbr_err), W'(0));
      check({tag, "_done_stable"}, W'(stab_err), W'(0));
      check({tag, "_post_in_ready"}, W'(in_ready), W'(1'b1));
      check({tag, "_post_out_valid"}, W'(out_valid), W'(1'b0));
    end
  endtask

  localparam logic [127:0] PT1 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] CT1 = 128'h7b5b7353_7a5a7555_6b43634b_426a4c65;
  localparam logic [127:0] PT2 = 128'h0fff0dff_0bff09ff_07ff05ff_03ff01ff;
  localparam logic [127:0] CT2 = 128'h7bff73ff_7aff75ff_6bff63ff_42ff4cff;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_state = '0; out_ready = 1'b0;
    rnd_in = '0; rnd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_in_ready", W'(in_ready), W'(1'b1));
    check("reset_out_valid", W'(out_valid), W'(1'b0));
    check("reset_rnd_ready", W'(rnd_ready), W'(1'b0));
    check("reset_sb_si", W'(sb_si), W'(0));
    check("reset_sb_r", W'(sb_r), W'(0));
    check("reset_out_state", out_state, '0);

    run_op("t1_nostall", PT1, 0, 0, 0, 0, 1'b0, 128'h0, 66, 64, CT1);
    run_op("t2_stalls", PT1, 3, 30, 0, 0, 1'b0, 128'h0, 72, 68, CT1);
    run_op("t3_hold", PT1, 0, 0, 10, 0, 1'b0, 128'h0, 66, 64, CT1);
    run_op("t4_abort", PT1, 0, 0, 0, 20, 1'b0, 128'h0, 0, 0, 128'h0);
    run_op("t4_after", PT1, 0, 0, 0, 0, 1'b0, 128'h0, 66, 64, CT1);
    run_op("t5_first", PT1, 0, 0, 0, 0, 1'b1, PT2, 66, 64, CT1);
    run_op("t5_second", PT2, 0, 0, 0, 0, 1'b0, 128'h0, 66, 64, CT2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
